// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: run/step/breakpoint clock-enable control and probe display mux.
// Define MIPS_DEBUG_BREAKPOINT_EN to build in PC breakpoint halting.
module mips_debug_ctrl #(
  parameter int PC_W    = 32,
  parameter int NPROBE  = 8,
  parameter int PROBE_W = 16,
  parameter int DEB_CYC = 50000,
  parameter int CNT_W   = 16,
  localparam int SEL_W  = (NPROBE > 1) ? $clog2(NPROBE) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run_sw,
  input  logic                      step_btn,
  input  logic                      bp_en_sw,
  input  logic [PC_W-1:0]           bp_addr,
  input  logic [PC_W-1:0]           pc,
  input  logic [SEL_W-1:0]          probe_sel,
  input  logic [NPROBE*PROBE_W-1:0] probe_bus,
  output logic                      cpu_en,
  output logic                      halted,
  output logic                      bp_hit,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [PROBE_W-1:0]        disp_data
);

  localparam int DB_W = $clog2(DEB_CYC + 1);

  typedef enum logic [1:0] {
    S_HALT,
    S_STEP,
    S_RUN,
    S_BRK
  } state_t;

  state_t state, state_nx;

  logic            sync1, sync2;
  logic            deb, deb_q;
  logic [DB_W-1:0] db_cnt;
  logic            step_req;
  logic            match;

  // Button sync + debounce: level flips after DEB_CYC stable samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      deb    <= 1'b0;
      deb_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= step_btn;
      sync2 <= sync1;
      deb_q <= deb;
      if (sync2 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEB_CYC - 1)) begin
        deb    <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign step_req = deb & ~deb_q;

`ifdef MIPS_DEBUG_BREAKPOINT_EN
  assign match = bp_en_sw && (pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en_sw, bp_addr, pc};
  assign match     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_HALT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_HALT: begin
        if (run_sw)        state_nx = S_RUN;
        else if (step_req) state_nx = S_STEP;
      end
      S_STEP: state_nx = S_HALT;
      S_RUN: begin
        if (!run_sw)       state_nx = S_HALT;
        else if (match)    state_nx = S_BRK;
      end
      S_BRK: begin
        if (step_req)      state_nx = S_STEP;
        else if (!run_sw)  state_nx = S_HALT;
      end
      default: state_nx = S_HALT;
    endcase
  end

  // Breakpoint PC is held off in RUN; only a step executes it
  always_comb begin
    cpu_en = 1'b0;
    halted = 1'b0;
    bp_hit = 1'b0;
    unique case (state)
      S_HALT: halted = 1'b1;
      S_STEP: cpu_en = 1'b1;
      S_RUN:  cpu_en = ~match;
      S_BRK: begin
        halted = 1'b1;
        bp_hit = 1'b1;
      end
      default: halted = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (cpu_en && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  logic [PROBE_W-1:0] ch [2**SEL_W];

  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
    if (k < NPROBE) begin : g_on
      assign ch[k] = probe_bus[k*PROBE_W +: PROBE_W];
    end else begin : g_off
      assign ch[k] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) disp_data <= '0;
    else        disp_data <= ch[probe_sel];
  end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// tb_mips_debug_ctrl: directed bench for the run/step/breakpoint controller.
// Breakpoint checks follow MIPS_DEBUG_BREAKPOINT_EN as the design does.
module tb_mips_debug_ctrl;

  localparam int PC_W    = 32;
  localparam int NPROBE  = 4;
  localparam int PROBE_W = 16;
  localparam int DEB_CYC = 4;
  localparam int CNT_W   = 4;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      run_sw = 1'b0;
  logic                      step_btn = 1'b0;
  logic                      bp_en_sw = 1'b0;
  logic [PC_W-1:0]           bp_addr = '0;
  logic [PC_W-1:0]           pc = '0;
  logic [1:0]                probe_sel = '0;
  logic [NPROBE*PROBE_W-1:0] probe_bus = '0;
  logic                      cpu_en;
  logic                      halted;
  logic                      bp_hit;
  logic [CNT_W-1:0]          cycle_count;
  logic [PROBE_W-1:0]        disp_data;

  int checks = 0;
  int errors = 0;
  int n_en   = 0;
  int n_halt = 0;

  always #5 clk = ~clk;

  mips_debug_ctrl #(
    .PC_W    (PC_W),
    .NPROBE  (NPROBE),
    .PROBE_W (PROBE_W),
    .DEB_CYC (DEB_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .bp_en_sw    (bp_en_sw),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .probe_sel   (probe_sel),
    .probe_bus   (probe_bus),
    .cpu_en      (cpu_en),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .cycle_count (cycle_count),
    .disp_data   (disp_data)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; the bench acts as the CPU and advances pc when enabled
  task automatic tick();
    logic en;
    #1;
    en = cpu_en;
    @(posedge clk);
    #1;
    if (en) begin
      pc = pc + 4;
      n_en++;
    end
    if (halted) n_halt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2;
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("rst_count", 32'(cycle_count), 32'd0);
    chk("rst_disp", 32'(disp_data), 32'd0);
    rst_n = 1'b1;

    // Run 5 cycles, then reset asynchronously mid-run
    probe_bus = {16'h1234, 16'hBEEF, 16'h5555, 16'hAAAA};
    probe_sel = 2'd0;
    run_sw = 1'b1;
    ticks(6);
    chk("run5_count", 32'(cycle_count), 32'd5);
    chk("run5_disp", 32'(disp_data), 32'hAAAA);
    chk("run5_halted", 32'(halted), 32'd0);
    chk("run5_cpu_en", 32'(cpu_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_cpu_en", 32'(cpu_en), 32'd0);
    chk("arst_halted", 32'(halted), 32'd1);
    chk("arst_count", 32'(cycle_count), 32'd0);
    chk("arst_disp", 32'(disp_data), 32'd0);
    rst_n = 1'b1;
    run_sw = 1'b0;

    // Bouncy press, then held: exactly one step
    n_en = 0;
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick();
    step_btn = 1'b1;
    ticks(10);
    step_btn = 1'b0;
    ticks(10);
    chk("step_en_cycles", 32'(n_en), 32'd1);
    chk("step_count", 32'(cycle_count), 32'd1);
    chk("step_halted", 32'(halted), 32'd1);
    chk("step_cpu_en", 32'(cpu_en), 32'd0);

    // Free run to saturation
    n_en = 0;
    run_sw = 1'b1;
    ticks(20);
    chk("sat_en_cycles", 32'(n_en), 32'd19);
    chk("sat_count", 32'(cycle_count), 32'd15);
    chk("sat_cpu_en", 32'(cpu_en), 32'd1);
    run_sw = 1'b0;
    tick();
    chk("stop_halted", 32'(halted), 32'd1);
    chk("stop_cpu_en", 32'(cpu_en), 32'd0);

    // Breakpoint at 0x10
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    pc = 32'h0C;
    bp_addr = 32'h10;
    bp_en_sw = 1'b1;
    run_sw = 1'b1;
    ticks(2);
    chk("bp_pc_at", pc, 32'h10);
`ifdef MIPS_DEBUG_BREAKPOINT_EN
    chk("bp_hold_en", 32'(cpu_en), 32'd0);
    tick();
    chk("bp_hit", 32'(bp_hit), 32'd1);
    chk("bp_halted", 32'(halted), 32'd1);
    ticks(3);
    chk("bp_pc_hold", pc, 32'h10);
    step_btn = 1'b1;
    for (int i = 0; i < 20 && bp_hit; i++) tick();
    chk("bp_step_leave", 32'(bp_hit), 32'd0);
    chk("bp_step_en", 32'(cpu_en), 32'd1);
    chk("bp_step_pc", pc, 32'h10);
    tick();
    chk("bp_after_pc", pc, 32'h14);
    chk("bp_after_halt", 32'(halted), 32'd1);
    chk("bp_after_count", 32'(cycle_count), 32'd2);
    tick();
    chk("bp_resume_halt", 32'(halted), 32'd0);
    chk("bp_resume_en", 32'(cpu_en), 32'd1);
    chk("bp_resume_pc", pc, 32'h14);
    step_btn = 1'b0;
    ticks(10);
`else
    chk("nobp_en", 32'(cpu_en), 32'd1);
    tick();
    chk("nobp_pc", pc, 32'h14);
    chk("nobp_hit", 32'(bp_hit), 32'd0);
    ticks(5);
    chk("nobp_hit_late", 32'(bp_hit), 32'd0);
    chk("nobp_halted", 32'(halted), 32'd0);
`endif

    // Probe display, and a step press ignored while running
    probe_sel = 2'd2;
    #1;
    chk("probe_latency", 32'(disp_data), 32'hAAAA);
    tick();
    chk("probe_ch2", 32'(disp_data), 32'hBEEF);
    probe_sel = 2'd3;
    tick();
    chk("probe_ch3", 32'(disp_data), 32'h1234);
    n_halt = 0;
    step_btn = 1'b1;
    ticks(12);
    step_btn = 1'b0;
    ticks(10);
    chk("run_step_ign", 32'(n_halt), 32'd0);
    chk("run_still", 32'(halted), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
